// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath/opcode widths, register addressing, ALU opcodes
// and the writeback-qualifying helper used by the operand-issue stage.
package cpu_pkg;

    localparam int WIDTH    = 8;
    localparam int OP_WIDTH = 3;
    localparam int REG_AW   = 2;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [OP_WIDTH-1:0] OP_NOP = 3'b000;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 3'b001;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 3'b010;
    localparam logic [OP_WIDTH-1:0] OP_AND = 3'b011;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 3'b100;
    localparam logic [OP_WIDTH-1:0] OP_XOR = 3'b101;

    // 110 and 111 are reserved and behave as NOPs, like 000.
    function automatic logic is_writing(input logic [OP_WIDTH-1:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 4-entry register file: one write port, three combinational read ports
// (rs1, rs2, debug). r0 is hardwired to zero; writes to it are dropped.
module reg_file #(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [cpu_pkg::REG_AW-1:0] waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [cpu_pkg::REG_AW-1:0] rs1_addr,
    output logic [WIDTH-1:0]           rs1_data,
    input  logic [cpu_pkg::REG_AW-1:0] rs2_addr,
    output logic [WIDTH-1:0]           rs2_data,
    input  logic [cpu_pkg::REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]           dbg_data
);
    import cpu_pkg::*;

    logic [WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : mem[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : mem[rs2_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/operand_issue.sv
// Operand-issue stage feeding the ALU: reads sources, loads the execute slot,
// writes the ALU result back on retire. OPERAND_FWD_EN enables result forwarding.
module operand_issue #(
    parameter int WIDTH    = cpu_pkg::WIDTH,
    parameter int OP_WIDTH = cpu_pkg::OP_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_WIDTH-1:0]        in_op,
    input  logic [cpu_pkg::REG_AW-1:0] in_rd,
    input  logic [cpu_pkg::REG_AW-1:0] in_rs1,
    input  logic [cpu_pkg::REG_AW-1:0] in_rs2,
    input  logic                       in_imm_sel,
    input  logic [WIDTH-1:0]           in_imm,
    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [OP_WIDTH-1:0]        ex_alu_op,
    output logic [WIDTH-1:0]           ex_op1,
    output logic [WIDTH-1:0]           ex_op2,
    output logic [cpu_pkg::REG_AW-1:0] ex_rd,
    input  logic [WIDTH-1:0]           ex_result,
    input  logic [cpu_pkg::REG_AW-1:0] dbg_sel,
    output logic [WIDTH-1:0]           dbg_data
);
    import cpu_pkg::*;

    logic             fire_in, fire_ex, live, hazard;
    logic             match1, match2, ex_writes;
    logic [WIDTH-1:0] rf_rs1, rf_rs2, op1_val, op2_val;

    reg_file #(.WIDTH(WIDTH)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (fire_ex && ex_writes),
        .waddr    (ex_rd),
        .wdata    (ex_result),
        .rs1_addr (in_rs1),
        .rs1_data (rf_rs1),
        .rs2_addr (in_rs2),
        .rs2_data (rf_rs2),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data)
    );

    // A slot targeting r0 never produces a value anyone can depend on.
    assign ex_writes = is_writing(ex_alu_op);
    assign live      = ex_valid && (ex_rd != '0) && ex_writes;
    assign match1    = live && (in_rs1 == ex_rd);
    assign match2    = live && !in_imm_sel && (in_rs2 == ex_rd);

`ifdef OPERAND_FWD_EN
    assign hazard  = 1'b0;
    assign op1_val = match1 ? ex_result : rf_rs1;
    assign op2_val = in_imm_sel ? in_imm : (match2 ? ex_result : rf_rs2);
`else
    assign hazard  = match1 || match2;
    assign op1_val = rf_rs1;
    assign op2_val = in_imm_sel ? in_imm : rf_rs2;
`endif

    assign in_ready = (!ex_valid || ex_ready) && !hazard;
    assign fire_in  = in_valid && in_ready;
    assign fire_ex  = ex_valid && ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_alu_op <= '0;
            ex_op1    <= '0;
            ex_op2    <= '0;
            ex_rd     <= '0;
        end else if (fire_in) begin
            ex_valid  <= 1'b1;
            ex_alu_op <= in_op;
            ex_op1    <= op1_val;
            ex_op2    <= op2_val;
            ex_rd     <= in_rd;
        end else if (fire_ex) begin
            ex_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue.sv
// Directed self-checking bench for operand_issue; a small ALU model drives
// ex_result from the registered ex_* outputs.
module tb_operand_issue;
    localparam int W  = 8;
    localparam int OW = 3;
    localparam logic [OW-1:0] NOP = 3'b000, ADD = 3'b001, SUB = 3'b010,
                              ANDO = 3'b011, ORO = 3'b100, XORO = 3'b101;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_imm_sel;
    logic [OW-1:0] in_op;
    logic [1:0]    in_rd, in_rs1, in_rs2;
    logic [W-1:0]  in_imm;
    logic          ex_valid, ex_ready;
    logic [OW-1:0] ex_alu_op;
    logic [W-1:0]  ex_op1, ex_op2, ex_result, dbg_data;
    logic [1:0]    ex_rd, dbg_sel;

    int tests = 0;
    int fails = 0;
    int retires = 0;
    int base;

    always #5 clk = ~clk;

    operand_issue #(.WIDTH(W), .OP_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm_sel(in_imm_sel), .in_imm(in_imm),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd),
        .ex_result(ex_result), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always_comb begin
        ex_result = '0;
        case (ex_alu_op)
            ADD:  ex_result = ex_op1 + ex_op2;
            SUB:  ex_result = ex_op1 - ex_op2;
            ANDO: ex_result = ex_op1 & ex_op2;
            ORO:  ex_result = ex_op1 | ex_op2;
            XORO: ex_result = ex_op1 ^ ex_op2;
            default: ex_result = '0;
        endcase
    end

    always @(posedge clk) if (ex_valid && ex_ready) retires <= retires + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dbg(input logic [1:0] sel, input logic [W-1:0] exp, input string tag);
        dbg_sel = sel;
        #1;
        chk(tag, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [OW-1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic sel, input logic [W-1:0] imm);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm_sel = sel; in_imm = imm;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm_sel = 1'b0; in_imm = '0; ex_ready = 1'b0; dbg_sel = '0;
        #3;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_op1", ex_op1, 0);
        chk("rst_ex_op2", ex_op2, 0);
        chk("rst_ex_alu_op", ex_alu_op, 0);
        for (int i = 0; i < 4; i++) dbg(i[1:0], 8'h00, "rst_dbg");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // r1 = r0 + 0x05, r2 = r0 + 0x03
        ex_ready = 1'b1;
        drive(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
        chk("add1_in_ready", in_ready, 1);
        tick();
        chk("add1_ex_valid", ex_valid, 1);
        chk("add1_ex_op1", ex_op1, 0);
        chk("add1_ex_op2", ex_op2, 8'h05);
        chk("add1_ex_rd", ex_rd, 1);
        drive(ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h03);
        chk("add2_in_ready", in_ready, 1);
        tick();
        dbg(2'd1, 8'h05, "r1_after_retire");
        chk("add2_ex_op2", ex_op2, 8'h03);

        // SUB r3 = r1 - r2, rs2 depends on the ADD in the slot
        drive(SUB, 2'd3, 2'd1, 2'd2, 1'b0, 8'hFF);
`ifdef OPERAND_FWD_EN
        chk("dep_in_ready_fwd", in_ready, 1);
        tick();
`else
        chk("dep_in_ready_stall", in_ready, 0);
        tick();
        chk("dep_bubble_ex_valid", ex_valid, 0);
        chk("dep_in_ready_after", in_ready, 1);
        dbg(2'd2, 8'h03, "r2_after_retire");
        tick();
`endif
        chk("sub_ex_valid", ex_valid, 1);
        chk("sub_ex_alu_op", ex_alu_op, SUB);
        chk("sub_ex_op1", ex_op1, 8'h05);
        chk("sub_ex_op2", ex_op2, 8'h03);

        // Backpressure with XOR r0 = r1 ^ r2 waiting
        ex_ready = 1'b0;
        drive(XORO, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_ex_valid", ex_valid, 1);
            chk("bp_ex_alu_op", ex_alu_op, SUB);
            chk("bp_ex_op1", ex_op1, 8'h05);
            chk("bp_ex_op2", ex_op2, 8'h03);
            chk("bp_ex_rd", ex_rd, 3);
            dbg(2'd3, 8'h00, "bp_r3_unchanged");
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        dbg(2'd3, 8'h02, "r3_sub_result");
        chk("xor_ex_alu_op", ex_alu_op, XORO);
        chk("xor_ex_op1", ex_op1, 8'h05);
        chk("xor_ex_op2", ex_op2, 8'h03);
        chk("xor_ex_rd", ex_rd, 0);

        // rs1 = r0 while the slot targets r0: no hazard, no forward
        drive(ORO, 2'd3, 2'd0, 2'd0, 1'b1, 8'h40);
        chk("r0_no_hazard", in_ready, 1);
        tick();
        chk("r0_no_fwd_op1", ex_op1, 0);
        chk("or_ex_op2", ex_op2, 8'h40);
        dbg(2'd0, 8'h00, "r0_stays_zero");
        drive(NOP, 2'd1, 2'd2, 2'd0, 1'b1, 8'hAA);
        chk("nop_in_ready", in_ready, 1);
        tick();
        dbg(2'd3, 8'h40, "r3_or_result");
        in_valid = 1'b0;
        tick();
        chk("nop_retired", ex_valid, 0);
        dbg(2'd1, 8'h05, "nop_r1_unchanged");

        // Four independent instructions back to back
        drive(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h11);
        chk("tp0_in_ready", in_ready, 1);
        tick();
        base = retires;
        drive(ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h22);
        chk("tp1_in_ready", in_ready, 1);
        tick();
        drive(ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h33);
        chk("tp2_in_ready", in_ready, 1);
        tick();
        drive(ORO, 2'd2, 2'd0, 2'd0, 1'b1, 8'h44);
        chk("tp3_in_ready", in_ready, 1);
        tick();
        chk("tp3_ex_op2", ex_op2, 8'h44);
        in_valid = 1'b0;
        tick();
        chk("tp_retire_count", retires - base, 4);
        chk("tp_drained", ex_valid, 0);
        dbg(2'd1, 8'h11, "tp_r1");
        dbg(2'd2, 8'h44, "tp_r2");
        dbg(2'd3, 8'h33, "tp_r3");

        // Reset mid-stall: in-flight ADD r1 must be dropped
        ex_ready = 1'b0;
        drive(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h77);
        tick();
        in_valid = 1'b0;
        tick();
        chk("stall_ex_valid", ex_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ex_valid", ex_valid, 0);
        chk("midrst_ex_op1", ex_op1, 0);
        chk("midrst_ex_op2", ex_op2, 0);
        for (int i = 0; i < 4; i++) dbg(i[1:0], 8'h00, "midrst_dbg");
        ex_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("postrst_ex_valid", ex_valid, 0);
        dbg(2'd1, 8'h00, "postrst_r1_no_write");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
